// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: credit-based stream wrapper around a fixed-latency,
// never-stalling AES-128 core, with a first-word-fall-through output FIFO.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake
//   in_state/in_key/in_tag      plaintext block, key, sideband tag
//   core_state/core_key         to the AES core (all-zero bubble when idle)
//   core_out                    ciphertext from the core, LATENCY cycles later
//   out_valid/out_ready         downstream handshake
//   out_data/out_tag            head-of-FIFO ciphertext and its tag
module aes_stream_ctrl #(
    parameter int LATENCY = 21,
    parameter int DEPTH   = 4,
    parameter int TAGW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_state,
    input  logic [127:0]    in_key,
    input  logic [TAGW-1:0] in_tag,
    output logic [127:0]    core_state,
    output logic [127:0]    core_key,
    input  logic [127:0]    core_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_data,
    output logic [TAGW-1:0] out_tag
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LATENCY + 1);

    logic               accept;
    logic               push;
    logic               pop;

    logic [LATENCY-1:0] vld_sr;
    logic [TAGW-1:0]    tag_sr [LATENCY];
    logic [IW-1:0]      inflight;

    logic [127:0]       mem_data [DEPTH];
    logic [TAGW-1:0]    mem_tag  [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      fifo_count;

    // Every block is either in the core or in the FIFO until popped, so
    // admitting only while their sum is below DEPTH means a push always
    // finds a free slot. Depends on registered state only.
    assign in_ready = (32'(fifo_count) + 32'(inflight)) < 32'(DEPTH);

    assign accept = in_valid && in_ready;
    assign push   = vld_sr[LATENCY-1];
    assign pop    = out_ready && (fifo_count != '0);

    assign core_state = accept ? in_state : '0;
    assign core_key   = accept ? in_key   : '0;

    assign out_valid = (fifo_count != '0);
    assign out_data  = mem_data[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];

    // Valid pipeline mirrors the core depth; tail marks core_out as live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    // Tag pipeline carries no reset; its contents only matter when the
    // matching valid bit is set.
    always_ff @(posedge clk) begin
        tag_sr[0] <= accept ? in_tag : '0;
        for (int i = 1; i < LATENCY; i++) begin
            tag_sr[i] <= tag_sr[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            unique case ({accept, push})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= core_out;
            mem_tag[wr_ptr]  <= tag_sr[LATENCY-1];
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
